perf_phase_mailbox: RTL and testbench

Memory-mapped cycle-count responder on the picoRV32 native memory bus for the MNIST firmware. Firmware writes START and end-of-phase MARKER words (0x7fffffff) to a mailbox register. The block times each inference phase and latches per-phase cycle counts. Firmware or the testbench reads the counts back through the same bus. It is the bus-responder counterpart of the read-data sentinel snoop: the CPU drives the markers explicitly and the counts are readable in software.

---
 rtl/perf_phase_mailbox.sv | 176 +++++++++++++++++
 tb/tb_perf_phase_mailbox.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/perf_phase_mailbox.sv
// perf_phase_mailbox
//   Memory-mapped cycle-count responder on the picoRV32 native bus. Firmware
//   writes START (0) and MARKER words to MARK; each phase length in clock
//   edges is latched into PHASE[k] and can be read back over the same bus.
//
//   Register map (byte offset inside the 256-byte window at BASE_ADDR):
//     0x00        MARK   (W)  0 = START, MARKER = end of phase
//     0x04        STATUS (R)  [0] running, [7:4] idx, [8] overflow, [9] done
//     0x08        LIVE   (R)  running cycle counter
//     0x10+4k     PHASE[k] (R), k < NUM_PHASES
//     other       read 0, writes acked and ignored
//
//   Ports:
//     clk        clock, all state on rising edge
//     reset      asynchronous active-high reset
//     mem_valid  request valid
//     mem_addr   byte address
//     mem_wdata  write data
//     mem_wstrb  byte strobes (0 = read)
//     mem_ready  one-cycle acknowledge
//     mem_rdata  read data while mem_ready, else 0
//     hit        mem_valid and address inside the window (combinational)
module perf_phase_mailbox #(
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter int unsigned NUM_PHASES = 4,
    parameter logic [31:0] MARKER     = 32'h7fff_ffff,
    parameter int unsigned READY_LAT  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        hit
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_t;

    state_t      state;
    logic [2:0]  wcnt;
    logic [7:0]  cap_off;
    logic [31:0] cap_wdata;
    logic [3:0]  cap_wstrb;

    logic [31:0] live;
    logic [31:0] live_inc;
    logic [3:0]  idx;
    logic        running;
    logic        done;
    logic        overflow;
    logic [31:0] phase [NUM_PHASES];

    logic        mark_wr;
    logic [31:0] status;

    assign hit      = mem_valid && (mem_addr[31:8] == BASE_ADDR[31:8]);
    assign live_inc = (live == '1) ? live : live + 32'd1;
    // Only a full-word, aligned write to MARK has any effect.
    assign mark_wr  = (cap_wstrb == 4'hF) && (cap_off == 8'h00);
    assign status   = {22'd0, done, overflow, idx, 3'd0, running};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            wcnt      <= '0;
            cap_off   <= '0;
            cap_wdata <= '0;
            cap_wstrb <= '0;
            mem_ready <= 1'b0;
            live      <= '0;
            idx       <= '0;
            running   <= 1'b0;
            done      <= 1'b0;
            overflow  <= 1'b0;
            for (int unsigned k = 0; k < NUM_PHASES; k++) begin
                phase[k] <= '0;
            end
        end else begin
            // Counting default; a MARK write below overrides it on its edge.
            if (running) begin
                live <= live_inc;
            end

            case (state)
                S_IDLE: begin
                    if (hit) begin
                        cap_off   <= mem_addr[7:0];
                        cap_wdata <= mem_wdata;
                        cap_wstrb <= mem_wstrb;
                        if (READY_LAT == 0) begin
                            state     <= S_ACK;
                            mem_ready <= 1'b1;
                        end else begin
                            state <= S_WAIT;
                            wcnt  <= 3'(READY_LAT - 1);
                        end
                    end
                end

                S_WAIT: begin
                    if (wcnt == '0) begin
                        state     <= S_ACK;
                        mem_ready <= 1'b1;
                    end else begin
                        wcnt <= wcnt - 3'd1;
                    end
                end

                S_ACK: begin
                    state     <= S_IDLE;
                    mem_ready <= 1'b0;
                    if (mark_wr) begin
                        if (cap_wdata == '0) begin
                            live     <= '0;
                            idx      <= '0;
                            running  <= 1'b1;
                            done     <= 1'b0;
                            overflow <= 1'b0;
                            for (int unsigned k = 0; k < NUM_PHASES; k++) begin
                                phase[k] <= '0;
                            end
                        end else if (cap_wdata == MARKER) begin
                            if (running) begin
                                // live_inc counts the marker edge itself.
                                for (int unsigned k = 0; k < NUM_PHASES; k++) begin
                                    if (idx == 4'(k)) begin
                                        phase[k] <= live_inc;
                                    end
                                end
                                live <= '0;
                                idx  <= idx + 4'd1;
                                if (idx == 4'(NUM_PHASES - 1)) begin
                                    running <= 1'b0;
                                    done    <= 1'b1;
                                end
                            end else begin
                                overflow <= 1'b1;
                            end
                        end
                    end
                end

                default: begin
                    state     <= S_IDLE;
                    mem_ready <= 1'b0;
                end
            endcase
        end
    end

    // Read data reflects current state during the acknowledge cycle.
    always_comb begin
        mem_rdata = '0;
        if (mem_ready) begin
            if (cap_off == 8'h04) begin
                mem_rdata = status;
            end else if (cap_off == 8'h08) begin
                mem_rdata = live;
            end else begin
                for (int unsigned k = 0; k < NUM_PHASES; k++) begin
                    if (cap_off == 8'(16 + 4 * k)) begin
                        mem_rdata = phase[k];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_perf_phase_mailbox.sv
module tb_perf_phase_mailbox;

    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam logic [31:0] MK   = 32'h7fff_ffff;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic [3:0]  mwstrb;
    logic [2:0]  vld;
    logic [2:0]  rdy;
    logic [2:0]  hit;
    logic [31:0] rdat [3];

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    perf_phase_mailbox #(.BASE_ADDR(BASE), .NUM_PHASES(4), .MARKER(MK), .READY_LAT(0)) u0 (
        .clk(clk), .reset(rst), .mem_valid(vld[0]), .mem_addr(maddr), .mem_wdata(mwdata),
        .mem_wstrb(mwstrb), .mem_ready(rdy[0]), .mem_rdata(rdat[0]), .hit(hit[0]));

    perf_phase_mailbox #(.BASE_ADDR(BASE), .NUM_PHASES(4), .MARKER(MK), .READY_LAT(2)) u2 (
        .clk(clk), .reset(rst), .mem_valid(vld[1]), .mem_addr(maddr), .mem_wdata(mwdata),
        .mem_wstrb(mwstrb), .mem_ready(rdy[1]), .mem_rdata(rdat[1]), .hit(hit[1]));

    perf_phase_mailbox #(.BASE_ADDR(BASE), .NUM_PHASES(4), .MARKER(MK), .READY_LAT(3)) u3 (
        .clk(clk), .reset(rst), .mem_valid(vld[2]), .mem_addr(maddr), .mem_wdata(mwdata),
        .mem_wstrb(mwstrb), .mem_ready(rdy[2]), .mem_rdata(rdat[2]), .hit(hit[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge following the ack edge.
    task automatic xfer(input int inst, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] ws, output logic [31:0] rd, output int ack);
        bit got;
        int n;
        got = 1'b0;
        n = 0;
        rd = '0;
        ack = -1;
        maddr = addr;
        mwdata = wd;
        mwstrb = ws;
        vld[inst] = 1'b1;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (rdy[inst]) begin
                got = 1'b1;
                rd = rdat[inst];
                ack = cyc + 1;
            end
        end
        checks++;
        assert (got) else begin
            failures++;
            $error("FAIL ack_timeout inst=%0d addr=0x%08h observed=no_ready expected=ready", inst, addr);
        end
        @(posedge clk);
        #1;
        vld[inst] = 1'b0;
        mwstrb = '0;
        @(negedge clk);
    endtask

    task automatic rd_reg(input int inst, input logic [31:0] off, output logic [31:0] v);
        int a;
        xfer(inst, BASE + off, 32'd0, 4'h0, v, a);
    endtask

    task automatic wr_reg(input int inst, input logic [31:0] off, input logic [31:0] d,
                          input logic [3:0] s, output int a);
        logic [31:0] v;
        xfer(inst, BASE + off, d, s, v, a);
    endtask

    // Full-word MARK write to u0 timed so its ack lands on edge 'target'.
    task automatic mark_at(input int target, input logic [31:0] d);
        int a;
        while (cyc < target - 2) @(negedge clk);
        wr_reg(0, 32'h0, d, 4'hF, a);
        chk("mark_ack_edge", 32'(a), 32'(target));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        int s, a1, a2, n, c;
        bit seen;

        rst = 1'b1;
        vld = '0;
        maddr = '0;
        mwdata = '0;
        mwstrb = '0;
        repeat (3) @(negedge clk);
        chk("reset_ready", {29'd0, rdy}, 32'd0);
        chk("reset_rdata_u0", rdat[0], 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Reset mid-WAIT on the READY_LAT=3 instance aborts the transaction.
        maddr = BASE + 32'h4;
        mwstrb = 4'h0;
        vld[2] = 1'b1;
        #1;
        chk("hit_in_window_u3", {31'd0, hit[2]}, 32'd1);
        @(negedge clk);
        seen = rdy[2];
        rst = 1'b1;
        vld[2] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rdy[2]) seen = 1'b1;
        end
        chk("no_ready_after_reset_abort", {31'd0, seen}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        rd_reg(2, 32'h4, v);
        chk("status_u3_after_reset", v, 32'd0);

        // READY_LAT=2: ready visible after the 3rd edge from request.
        maddr = BASE + 32'h8;
        vld[1] = 1'b1;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 10) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            seen = rdy[1];
        end
        chk("latency_u2_edges", 32'(n), 32'd3);
        chk("live_u2_read", rdat[1], 32'd0);
        @(posedge clk);
        #1;
        vld[1] = 1'b0;
        @(negedge clk);

        // Back-to-back requests on READY_LAT=0 are two edges apart.
        xfer(0, BASE + 32'h4, 32'd0, 4'h0, v, a1);
        xfer(0, BASE + 32'h4, 32'd0, 4'h0, v, a2);
        chk("b2b_period", 32'(a2 - a1), 32'd2);
        chk("rdata_zero_when_idle", rdat[0], 32'd0);

        // START then MARKER 100 edges later.
        wr_reg(0, 32'h0, 32'd0, 4'hF, s);
        mark_at(s + 100, MK);
        rd_reg(0, 32'h10, v);
        chk("phase0_100", v, 32'd100);
        rd_reg(0, 32'h4, v);
        chk("status_after_one_marker", v, 32'h0000_0011);

        // Restart while running, then four phases of 10/20/30/40.
        wr_reg(0, 32'h0, 32'd0, 4'hF, s);
        rd_reg(0, 32'h10, v);
        chk("phase0_cleared_by_restart", v, 32'd0);
        rd_reg(0, 32'h4, v);
        chk("status_after_restart", v, 32'h0000_0001);
        mark_at(s + 10, MK);
        mark_at(s + 30, MK);
        mark_at(s + 60, MK);
        mark_at(s + 100, MK);
        rd_reg(0, 32'h10, v);
        chk("phase0_10", v, 32'd10);
        rd_reg(0, 32'h14, v);
        chk("phase1_20", v, 32'd20);
        rd_reg(0, 32'h18, v);
        chk("phase2_30", v, 32'd30);
        rd_reg(0, 32'h1C, v);
        chk("phase3_40", v, 32'd40);
        rd_reg(0, 32'h4, v);
        chk("status_done", v, 32'h0000_0240);
        wr_reg(0, 32'h0, MK, 4'hF, a1);
        rd_reg(0, 32'h4, v);
        chk("status_overflow", v, 32'h0000_0340);
        rd_reg(0, 32'h1C, v);
        chk("phase3_kept_after_overflow", v, 32'd40);

        // Ignored writes: partial strobe, other data, read-only offset.
        wr_reg(0, 32'h0, 32'd0, 4'hF, a1);
        wr_reg(0, 32'h0, MK, 4'h3, a1);
        wr_reg(0, 32'h0, 32'h0000_1234, 4'hF, a1);
        wr_reg(0, 32'h4, MK, 4'hF, a1);
        rd_reg(0, 32'h4, v);
        chk("status_after_ignored_writes", v, 32'h0000_0001);
        rd_reg(0, 32'h10, v);
        chk("phase0_after_ignored_writes", v, 32'd0);

        // Saturation of LIVE and of the latched phase value.
        force u0.live = 32'hFFFF_FFFE;
        #1;
        release u0.live;
        c = cyc;
        mark_at(c + 5, MK);
        rd_reg(0, 32'h8, v);
        chk("live_restarts_after_marker", v, 32'd1);
        rd_reg(0, 32'h10, v);
        chk("phase0_saturated", v, 32'hFFFF_FFFF);

        // Outside the window: no hit, never acked.
        maddr = BASE + 32'hFC;
        vld[0] = 1'b1;
        #1;
        chk("hit_last_word", {31'd0, hit[0]}, 32'd1);
        maddr = BASE + 32'h100;
        #1;
        chk("hit_outside", {31'd0, hit[0]}, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rdy[0]) seen = 1'b1;
        end
        chk("no_ready_outside", {31'd0, seen}, 32'd0);
        vld[0] = 1'b0;
        @(negedge clk);

        // Unmapped and write-only offsets read 0.
        rd_reg(0, 32'h0C, v);
        chk("read_0x0c", v, 32'd0);
        rd_reg(0, 32'h20, v);
        chk("read_0x20", v, 32'd0);
        rd_reg(0, 32'h00, v);
        chk("read_mark", v, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
